// File: rtl/ahb_slave_resp_mux_if.sv
// rtl/ahb_slave_resp_mux_if.sv - bus bundle between the AHB response mux and its master/slave side
// Master side drives the address-phase decode and slave responses; the mux (slave modport) returns the selected response.
interface ahb_slave_resp_mux_if #(
    parameter int CHANNEL_NUM = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int PAY_LOAD    = DATA_WIDTH + 2
);
    logic [CHANNEL_NUM-1:0]               addr_sel;
    logic [1:0]                           htrans;
    logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_in;
    logic [PAY_LOAD-1:0]                  payload_out;
    logic [CHANNEL_NUM-1:0]               data_sel;
    logic [7:0]                           err_cnt;

    modport master (
        output addr_sel, htrans, payload_in,
        input  payload_out, data_sel, err_cnt
    );

    modport slave (
        input  addr_sel, htrans, payload_in,
        output payload_out, data_sel, err_cnt
    );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// rtl/ahb_slave_resp_mux.sv - AHB data-phase response mux with optional default slave (AHB_DEFAULT_SLAVE_EN)
// Payload layout per channel is {hreadyout, hresp, hrdata}; payload_out MSB is the bus HREADY.
module ahb_slave_resp_mux #(
    parameter int CHANNEL_NUM = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int PAY_LOAD    = DATA_WIDTH + 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_slave_resp_mux_if.slave  bus
);
    logic                   accept;
    logic                   active;
    logic                   one_hot;
    logic [CHANNEL_NUM-1:0] data_sel_d;
    logic [CHANNEL_NUM-1:0] data_sel_q;
    logic [PAY_LOAD-1:0]    dflt_resp;
    logic [PAY_LOAD-1:0]    mux_out;

    assign accept  = bus.payload_out[PAY_LOAD-1];
    assign active  = bus.htrans[1];
    assign one_hot = ($countones(bus.addr_sel) == 1);

    always_comb begin
        data_sel_d = data_sel_q;
        if (accept) begin
            data_sel_d = (active && one_hot) ? bus.addr_sel : '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_sel_q <= '0;
        end else begin
            data_sel_q <= data_sel_d;
        end
    end

    // data_sel_q is one-hot or zero, so an OR of masked channels is a plain mux
    always_comb begin
        mux_out = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (data_sel_q[i]) begin
                mux_out = mux_out | bus.payload_in[i];
            end
        end
        bus.payload_out = (data_sel_q == '0) ? dflt_resp : mux_out;
    end

    assign bus.data_sel = data_sel_q;

`ifdef AHB_DEFAULT_SLAVE_EN
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    ds_state_e  state_d;
    ds_state_e  state_q;
    logic [7:0] err_cnt_d;
    logic [7:0] err_cnt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= DS_IDLE;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // ERR1 drives HREADY low, so it never accepts and always moves on to ERR2
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_ERR1: state_d = DS_ERR2;
            default: begin
                if (accept) begin
                    state_d = (active && !one_hot) ? DS_ERR1 : DS_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        dflt_resp = {2'b10, {DATA_WIDTH{1'b0}}};
        case (state_q)
            DS_ERR1: dflt_resp = {2'b01, {DATA_WIDTH{1'b0}}};
            DS_ERR2: dflt_resp = {2'b11, {DATA_WIDTH{1'b0}}};
            default: dflt_resp = {2'b10, {DATA_WIDTH{1'b0}}};
        endcase
        err_cnt_d = err_cnt_q;
        if ((state_d == DS_ERR1) && (state_q != DS_ERR1) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign dflt_resp   = {2'b10, {DATA_WIDTH{1'b0}}};
    assign bus.err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// tb/tb_ahb_slave_resp_mux.sv - directed table, corner sequences and random check of ahb_slave_resp_mux
// Expected values come from a countdown-based response model; default slave presence follows AHB_DEFAULT_SLAVE_EN.
module tb_ahb_slave_resp_mux;
    localparam int CN = 4;
    localparam int DW = 32;
    localparam int PL = DW + 2;
`ifdef AHB_DEFAULT_SLAVE_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_slave_resp_mux_if #(.CHANNEL_NUM(CN), .DATA_WIDTH(DW), .PAY_LOAD(PL)) bus ();

    ahb_slave_resp_mux #(.CHANNEL_NUM(CN), .DATA_WIDTH(DW), .PAY_LOAD(PL)) dut (
        .HCLK    (hclk),
        .HRESETn (hresetn),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // model: selected channel (-1 = default), error cycles still to show, saturating error count
    int m_sel;
    int m_err;
    int m_cnt;
    logic [PL-1:0] pin [CN];
    logic [CN-1:0] cur_a;
    logic [1:0]    cur_t;

    typedef struct {
        logic [3:0] a;
        logic [1:0] t;
        logic [3:0] rdy;
        logic [3:0] rsp;
        logic [3:0] e_sel;
        logic       e_rdy;
        logic       e_rsp;
        int         e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PL-1:0] m_out();
        if (m_sel >= 0) return pin[m_sel];
        if (m_err == 2) return {2'b01, {DW{1'b0}}};
        if (m_err == 1) return {2'b11, {DW{1'b0}}};
        return {2'b10, {DW{1'b0}}};
    endfunction

    task automatic model_reset();
        m_sel = -1;
        m_err = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [PL-1:0] o;
        o = m_out();
        if (m_err == 2) begin
            m_err = 1;
        end else if (o[PL-1]) begin
            if (cur_t[1] && $countones(cur_a) == 1) begin
                for (int i = 0; i < CN; i++) if (cur_a[i]) m_sel = i;
                m_err = 0;
            end else begin
                m_sel = -1;
                m_err = 0;
                if (DS && cur_t[1]) begin
                    m_err = 2;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [CN-1:0] es;
        es = (m_sel >= 0) ? CN'(1 << m_sel) : '0;
        chk("payload_out", bus.payload_out, m_out());
        chk("data_sel", PL'(bus.data_sel), PL'(es));
        chk("err_cnt", PL'(bus.err_cnt), PL'(m_cnt));
    endtask

    task automatic step(input logic [CN-1:0] a, input logic [1:0] t,
                        input logic [CN-1:0] rdy, input logic [CN-1:0] rsp, input bit rnd);
        @(negedge hclk);
        cur_a = a;
        cur_t = t;
        for (int i = 0; i < CN; i++) begin
            pin[i] = {rdy[i], rsp[i], rnd ? DW'($urandom) : (32'hA5A5_0000 | 32'(i))};
            bus.payload_in[i] = pin[i];
        end
        bus.addr_sel = a;
        bus.htrans   = t;
        #1;
        model_check();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 2'b10, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 0};
        tbl[1]  = '{4'b0100, 2'b10, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b0, 0};
        tbl[2]  = '{4'b0001, 2'b10, 4'hB, 4'h0, 4'b0100, 1'b0, 1'b0, 0};
        tbl[3]  = '{4'b0001, 2'b10, 4'hB, 4'h0, 4'b0100, 1'b0, 1'b0, 0};
        tbl[4]  = '{4'b0001, 2'b10, 4'hB, 4'h0, 4'b0100, 1'b0, 1'b0, 0};
        tbl[5]  = '{4'b0001, 2'b10, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 0};
        tbl[6]  = '{4'b0000, 2'b10, 4'hF, 4'h0, 4'b0000, !DS,  DS,   DS ? 1 : 0};
        tbl[7]  = '{4'b0000, 2'b10, 4'hF, 4'h0, 4'b0000, 1'b1, DS,   DS ? 1 : 0};
        tbl[8]  = '{4'b0011, 2'b10, 4'hF, 4'h0, 4'b0000, !DS,  DS,   DS ? 2 : 0};
        tbl[9]  = '{4'b0001, 2'b10, 4'hF, 4'h0, DS ? 4'b0000 : 4'b0001, 1'b1, DS, DS ? 2 : 0};
        tbl[10] = '{4'b0000, 2'b00, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, DS ? 2 : 0};
        tbl[11] = '{4'b1000, 2'b01, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, DS ? 2 : 0};
        tbl[12] = '{4'b1000, 2'b11, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, DS ? 2 : 0};
        tbl[13] = '{4'b0010, 2'b10, 4'h7, 4'h8, 4'b1000, 1'b0, 1'b1, DS ? 2 : 0};
        tbl[14] = '{4'b0010, 2'b10, 4'hF, 4'h8, 4'b0010, 1'b1, 1'b0, DS ? 2 : 0};

        bus.addr_sel = '0;
        bus.htrans   = 2'b00;
        for (int i = 0; i < CN; i++) begin
            pin[i] = '0;
            bus.payload_in[i] = '0;
        end
        cur_a = '0;
        cur_t = 2'b00;
        model_reset();
        repeat (2) @(negedge hclk);
        #1;
        chk("reset_payload", bus.payload_out, {2'b10, {DW{1'b0}}});
        chk("reset_data_sel", PL'(bus.data_sel), '0);
        chk("reset_err_cnt", PL'(bus.err_cnt), '0);
        hresetn = 1'b1;

        for (int k = 0; k < 15; k++) begin
            step(tbl[k].a, tbl[k].t, tbl[k].rdy, tbl[k].rsp, 1'b0);
            chk($sformatf("tbl%0d_sel", k), PL'(bus.data_sel), PL'(tbl[k].e_sel));
            chk($sformatf("tbl%0d_hready", k), PL'(bus.payload_out[PL-1]), PL'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_hresp", k), PL'(bus.payload_out[PL-2]), PL'(tbl[k].e_rsp));
            chk($sformatf("tbl%0d_err", k), PL'(bus.err_cnt), PL'(tbl[k].e_err));
            if (k == 0) chk("tbl0_data", bus.payload_out, {2'b10, 32'hA5A5_0001});
        end

        for (int k = 0; k < 600; k++) step(4'b0000, 2'b10, 4'hF, 4'h0, 1'b0);
        chk("err_saturate", PL'(bus.err_cnt), PL'(DS ? 255 : 0));
        step(4'b0000, 2'b00, 4'hF, 4'h0, 1'b0);
        chk("idle_no_count", PL'(bus.err_cnt), PL'(DS ? 255 : 0));
        chk("idle_payload", bus.payload_out, {2'b10, {DW{1'b0}}});

        step(4'b0000, 2'b10, 4'hF, 4'h0, 1'b0);
        chk("pre_reset_hready", PL'(bus.payload_out[PL-1]), PL'(!DS));
        hresetn = 1'b0;
        #1;
        chk("async_reset_payload", bus.payload_out, {2'b10, {DW{1'b0}}});
        chk("async_reset_data_sel", PL'(bus.data_sel), '0);
        chk("async_reset_err_cnt", PL'(bus.err_cnt), '0);
        model_reset();
        @(negedge hclk);
        hresetn = 1'b1;
        step(4'b1000, 2'b10, 4'hF, 4'h0, 1'b0);
        chk("post_reset_sel", PL'(bus.data_sel), PL'(4'b1000));
        chk("post_reset_data", bus.payload_out, {2'b10, 32'hA5A5_0003});

        for (int k = 0; k < 3000; k++) begin
            logic [CN-1:0] a;
            logic [CN-1:0] rdy;
            a   = ($urandom_range(0, 9) < 6) ? CN'(1 << $urandom_range(0, CN - 1)) : CN'($urandom);
            rdy = ($urandom_range(0, 3) == 0) ? CN'($urandom) : '1;
            step(a, 2'($urandom), rdy, CN'($urandom) & CN'($urandom), 1'b1);
        end
        @(negedge hclk);
        #1;
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
